// File: rtl/rca_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rca_bist_ctrl
// Purpose  : Drives directed and LFSR vectors into a 64-bit adder and checks
//            each result against a 65-bit reference add.
// Revision : 1.0  initial release
// ============================================================================
module rca_bist_ctrl #(
  parameter int                 WIDTH         = 64,
  parameter int                 NUM_VECTORS   = 256,
  parameter int                 SETTLE_CYCLES = 2,
  parameter logic [WIDTH-1:0]   SEED          = 64'h0123456789ABCDEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             c_in,
  input  logic [WIDTH-1:0] sum,
  input  logic             c_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_cin,
  output logic [15:0]      vec_idx
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int               SETTLE_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [WIDTH-1:0] LFSR_MASK  = WIDTH'(64'hD800_0000_0000_0000);
  localparam logic [15:0]      LAST_IDX   = 16'(NUM_VECTORS - 1);
  localparam int               HALF       = WIDTH / 2;

  logic [2:0]          state_q,    state_d;
  logic [WIDTH-1:0]    a_q,        a_d;
  logic [WIDTH-1:0]    b_q,        b_d;
  logic                cin_q,      cin_d;
  logic [15:0]         err_q,      err_d;
  logic [15:0]         vec_q,      vec_d;
  logic [WIDTH-1:0]    fail_a_q,   fail_a_d;
  logic [WIDTH-1:0]    fail_b_q,   fail_b_d;
  logic                fail_cin_q, fail_cin_d;
  logic [WIDTH-1:0]    lfsr_q,     lfsr_d;
  logic [SETTLE_W-1:0] settle_q,   settle_d;
  logic                pass_q,     pass_d;

  logic [WIDTH:0]      exp_sum;
  logic                mismatch;
  logic [WIDTH-1:0]    lfsr_next;
  logic [15:0]         err_upd;

  // Galois step: shift right, fold the mask in when a 1 falls off the end.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : '0);
  endfunction

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    err_d      = err_q;
    vec_d      = vec_q;
    fail_a_d   = fail_a_q;
    fail_b_d   = fail_b_q;
    fail_cin_d = fail_cin_q;
    lfsr_d     = lfsr_q;
    settle_d   = settle_q;
    pass_d     = pass_q;
    err_upd    = err_q;

    exp_sum   = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
    mismatch  = (exp_sum != {c_out, sum});
    lfsr_next = lfsr_step(lfsr_q);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_LOAD;
          vec_d      = 16'd0;
          err_d      = 16'd0;
          fail_a_d   = '0;
          fail_b_d   = '0;
          fail_cin_d = 1'b0;
          lfsr_d     = SEED;
          pass_d     = 1'b0;
        end
      end
      S_LOAD: begin
        case (vec_q)
          16'd0: begin a_d = '0;              b_d = '0;       cin_d = 1'b0; end
          16'd1: begin a_d = '1;              b_d = WIDTH'(1); cin_d = 1'b1; end
          16'd2: begin a_d = WIDTH'(500000);  b_d = WIDTH'(1); cin_d = 1'b1; end
          16'd3: begin a_d = WIDTH'(500000);  b_d = WIDTH'(1); cin_d = 1'b0; end
          default: begin
            lfsr_d = lfsr_next;
            a_d    = lfsr_next;
            b_d    = {lfsr_next[HALF-1:0], lfsr_next[WIDTH-1:HALF]};
            cin_d  = lfsr_next[0] ^ lfsr_next[WIDTH-1];
          end
        endcase
        settle_d = '0;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
          state_d = S_CHECK;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          if (err_q != 16'hFFFF) begin
            err_upd = err_q + 16'd1;
          end
          if (err_q == 16'd0) begin
            fail_a_d   = a_q;
            fail_b_d   = b_q;
            fail_cin_d = cin_q;
          end
        end
        err_d = err_upd;
        if (vec_q == LAST_IDX) begin
          state_d = S_DONE;
          pass_d  = (err_upd == 16'd0);
        end else begin
          vec_d   = vec_q + 16'd1;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      err_q      <= 16'd0;
      vec_q      <= 16'd0;
      fail_a_q   <= '0;
      fail_b_q   <= '0;
      fail_cin_q <= 1'b0;
      lfsr_q     <= SEED;
      settle_q   <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cin_q      <= cin_d;
      err_q      <= err_d;
      vec_q      <= vec_d;
      fail_a_q   <= fail_a_d;
      fail_b_q   <= fail_b_d;
      fail_cin_q <= fail_cin_d;
      lfsr_q     <= lfsr_d;
      settle_q   <= settle_d;
      pass_q     <= pass_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign c_in      = cin_q;
  assign busy      = (state_q == S_LOAD) || (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_a    = fail_a_q;
  assign fail_b    = fail_b_q;
  assign fail_cin  = fail_cin_q;
  assign vec_idx   = vec_q;

endmodule
`default_nettype wire
